regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
- Parametrised successor to the datapath register file: one write port, two registered read ports, with configurable data width and depth.
- Synchronous reset starts a hardware clear sweep that zeroes every entry, one per cycle. A Busy flag is raised while the sweep runs.
- Register 0 is optionally hardwired to zero.
- Sits between decode (read addresses) and writeback (C port) in the CPU datapath.

Parameters:
- DATA_WIDTH, 32: width of each register and of the data ports.
- ADDR_WIDTH, 4: width of every address port.
- DEPTH, 2**ADDR_WIDTH: number of registers. Legal range 2..2**ADDR_WIDTH.
- ZERO_REG, 1: when 1, entry 0 always reads 0 and writes to it are dropped. When 0, entry 0 is an ordinary register.

Ports:
- Clk  input  1  single clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- A_Address  input  ADDR_WIDTH  read port A address.
- B_Address  input  ADDR_WIDTH  read port B address.
- C_Address  input  ADDR_WIDTH  write address.
- C_Data  input  DATA_WIDTH  write data.
- Write  input  1  write enable.
- A_Data  output  DATA_WIDTH  registered read data, port A.
- B_Data  output  DATA_WIDTH  registered read data, port B.
- Busy  output  1  high while the clear sweep is in progress.

Interface decision: one clock, Clk; Reset is synchronous and active-high.

Behaviour:
- Reset values: on a rising edge with Reset=1, A_Data=0, B_Data=0, Busy=1, state=CLEAR, clear counter=0. Holding Reset high keeps this state and the counter stays at 0.
- State machine has two states, CLEAR and IDLE.
- CLEAR (Reset=0):
  - Each edge writes 0 to entry[cnt], then increments cnt.
  - When cnt==DEPTH-1, that entry is cleared and the state becomes IDLE.
  - Busy is high for exactly DEPTH cycles after Reset falls, then drops on the following edge.
- During CLEAR:
  - Write is ignored; external writes are lost, not queued.
  - A_Data and B_Data are driven to 0.
- Reset asserted mid-sweep returns to CLEAR with cnt=0; the sweep restarts from entry 0.
- IDLE, write path: on an edge with Write=1, entry[C_Address] <= C_Data, except:
  - dropped if C_Address >= DEPTH;
  - dropped if ZERO_REG=1 and C_Address==0.
- IDLE, read path: one-cycle latency. Each edge captures:
  - A_Data <= entry[A_Address]
  - B_Data <= entry[B_Address]
  - out-of-range address (>= DEPTH) reads 0;
  - address 0 reads 0 when ZERO_REG=1.
- Read and write to the same address on the same edge: the read captures the pre-write value unless REGFILE_BYPASS_EN is defined (see below).
- A and B may carry the same address; both return identical data.
- Widths: no truncation or extension inside the block. C_Data is stored at full DATA_WIDTH.
- No other outputs; Busy is the only status indication.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - In IDLE, if Write=1, the write is legal (in range, not a dropped zero-register write), and A_Address==C_Address, then A_Data <= C_Data on that same edge. Port B is handled identically.
  - A dropped write is never forwarded.
- Undefined: the same-edge read returns the old entry value; the new value is visible one cycle later.

Test Plan:
- Reset sweep, DEPTH=16: hold Reset 3 cycles then release.
  - Busy stays 1 for exactly 16 edges, then 0.
  - Reading all addresses afterwards returns 0.
  - A Write of 0xDEADBEEF to address 5 issued during the sweep is absent afterwards.
- Basic write/read: write 0x12345678 to addr 3, then read A=3, B=3 the next cycle.
  - Both A_Data and B_Data equal 0x12345678 one cycle after the read addresses are applied.
- Zero register, ZERO_REG=1: write 0xFFFFFFFF to addr 0, then read A=0.
  - A_Data=0.
  - Repeat with ZERO_REG=0: A_Data=0xFFFFFFFF.
- Same-edge read/write: addr 7 holds 0x11; on one edge write 0x22 to addr 7 with A_Address=7.
  - Without REGFILE_BYPASS_EN: A_Data=0x11 after that edge, 0x22 after the next edge.
  - With REGFILE_BYPASS_EN: A_Data=0x22 immediately.
- Mid-sweep reset, DEPTH=16: pulse Reset for 1 cycle at sweep cycle 9.
  - Busy remains high for 16 further cycles after the pulse releases; cnt restarts at 0.
- Parameter sweep: DATA_WIDTH=16, ADDR_WIDTH=5, DEPTH=20.
  - A write to addr 25 is dropped and reading addr 25 returns 0.
  - Writing 0xA5A5 to addr 19 reads back as 0xA5A5.

Source files
------------

// File: rtl/regfile_param.sv
// Parametrised register file: one write port, two registered read ports, clear sweep after reset.
// Optional macro REGFILE_BYPASS_EN forwards a legal same-edge write to matching read ports.
module regfile_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 2**ADDR_WIDTH,
    parameter int ZERO_REG   = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] A_Address,
    input  logic [ADDR_WIDTH-1:0] B_Address,
    input  logic [ADDR_WIDTH-1:0] C_Address,
    input  logic [DATA_WIDTH-1:0] C_Data,
    input  logic                  Write,
    output logic [DATA_WIDTH-1:0] A_Data,
    output logic [DATA_WIDTH-1:0] B_Data,
    output logic                  Busy
);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic [ADDR_WIDTH-1:0]   cnt_next;
    logic                    clr_en;
    logic                    wr_en;
    logic [DATA_WIDTH-1:0]   a_next;
    logic [DATA_WIDTH-1:0]   b_next;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // An address is live when it maps to a real entry that is not the hardwired zero register.
    function automatic logic addr_live(input logic [ADDR_WIDTH-1:0] addr);
        return (int'(addr) < DEPTH) && !((ZERO_REG != 0) && (addr == '0));
    endfunction

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        clr_en     = 1'b0;
        wr_en      = 1'b0;
        a_next     = '0;
        b_next     = '0;
        case (state)
            CLEAR: begin
                clr_en   = 1'b1;
                cnt_next = cnt + 1'b1;
                if (int'(cnt) == DEPTH - 1) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            IDLE: begin
                wr_en  = Write && addr_live(C_Address);
                a_next = addr_live(A_Address) ? mem[A_Address] : '0;
                b_next = addr_live(B_Address) ? mem[B_Address] : '0;
`ifdef REGFILE_BYPASS_EN
                // Only writes that will actually land are forwarded.
                if (wr_en && (A_Address == C_Address)) a_next = C_Data;
                if (wr_en && (B_Address == C_Address)) b_next = C_Data;
`endif
            end
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Read ports are forced to zero while clearing because a_next/b_next default to zero.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            A_Data <= '0;
            B_Data <= '0;
        end else begin
            A_Data <= a_next;
            B_Data <= b_next;
        end
    end

    // Storage has no reset of its own; the sweep zeroes it one entry per cycle.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (clr_en) begin
                mem[cnt] <= '0;
            end else if (wr_en) begin
                mem[C_Address] <= C_Data;
            end
        end
    end

    assign Busy = (state == CLEAR);

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three instances (default, ZERO_REG=0, 16-bit/5-bit/20-deep) checked against array models.
module tb_regfile_param;

    logic        Clk;
    logic        Reset;

    logic [3:0]  a0, b0, c0;
    logic [31:0] d0, ra0, rb0;
    logic        w0, busy0;

    logic [3:0]  a1, b1, c1;
    logic [31:0] d1, ra1, rb1;
    logic        w1, busy1;

    logic [4:0]  a2, b2, c2;
    logic [15:0] d2, ra2, rb2;
    logic        w2, busy2;

    logic [31:0] m0 [16];
    logic [31:0] m1 [16];
    logic [15:0] m2 [32];
    logic [31:0] exp_q [$];

    int tests_run    = 0;
    int tests_failed = 0;

    regfile_param u_dut0 (
        .Clk(Clk), .Reset(Reset),
        .A_Address(a0), .B_Address(b0), .C_Address(c0), .C_Data(d0), .Write(w0),
        .A_Data(ra0), .B_Data(rb0), .Busy(busy0)
    );

    regfile_param #(.ZERO_REG(0)) u_dut1 (
        .Clk(Clk), .Reset(Reset),
        .A_Address(a1), .B_Address(b1), .C_Address(c1), .C_Data(d1), .Write(w1),
        .A_Data(ra1), .B_Data(rb1), .Busy(busy1)
    );

    regfile_param #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .DEPTH(20), .ZERO_REG(1)) u_dut2 (
        .Clk(Clk), .Reset(Reset),
        .A_Address(a2), .B_Address(b2), .C_Address(c2), .C_Data(d2), .Write(w2),
        .A_Data(ra2), .B_Data(rb2), .Busy(busy2)
    );

    // Clock and reset
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        Reset = 1'b1;
        {a0, b0, c0, d0, w0} = '0;
        {a1, b1, c1, d1, w1} = '0;
        {a2, b2, c2, d2, w2} = '0;
    end

    // Reference model
    function automatic bit legal(int addr, int depth, bit zr);
        return (addr < depth) && !(zr && addr == 0);
    endfunction

    function automatic logic [31:0] exp0(int a);
`ifdef REGFILE_BYPASS_EN
        if (w0 && legal(int'(c0), 16, 1'b1) && a == int'(c0)) return d0;
`endif
        return legal(a, 16, 1'b1) ? m0[a] : 32'h0;
    endfunction

    function automatic logic [31:0] exp1(int a);
`ifdef REGFILE_BYPASS_EN
        if (w1 && legal(int'(c1), 16, 1'b0) && a == int'(c1)) return d1;
`endif
        return legal(a, 16, 1'b0) ? m1[a] : 32'h0;
    endfunction

    function automatic logic [31:0] exp2(int a);
`ifdef REGFILE_BYPASS_EN
        if (w2 && legal(int'(c2), 20, 1'b1) && a == int'(c2)) return {16'h0, d2};
`endif
        return legal(a, 20, 1'b1) ? {16'h0, m2[a]} : 32'h0;
    endfunction

    // Driver tasks
    task automatic commit();
        if (w0 && legal(int'(c0), 16, 1'b1)) m0[c0] = d0;
        if (w1 && legal(int'(c1), 16, 1'b0)) m1[c1] = d1;
        if (w2 && legal(int'(c2), 20, 1'b1)) m2[c2] = d2;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) begin
            if (i < 16) begin
                m0[i] = '0;
                m1[i] = '0;
            end
            m2[i] = '0;
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick_idle();
        tick();
        commit();
        w0 = 1'b0;
        w1 = 1'b0;
        w2 = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        a0 = 4'd5; b0 = 4'd9; a2 = 5'd5; b2 = 5'd19;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests_run++;
            if (busy0 !== 1'b1 || busy2 !== 1'b1 || ra0 !== 32'h0 || rb0 !== 32'h0 || ra2 !== 16'h0) begin
                tests_failed++;
                $display("FAIL reset_state: busy0=%b busy2=%b ra0=%h rb0=%h ra2=%h, required busy=1 data=0",
                         busy0, busy2, ra0, rb0, ra2);
            end
        end
        Reset = 1'b0;
        clear_model();
        w0 = 1'b1; c0 = 4'd5; d0 = 32'hDEADBEEF;
        w1 = 1'b1; c1 = 4'd5; d1 = 32'hDEADBEEF;
        w2 = 1'b1; c2 = 5'd5; d2 = 16'hBEEF;
        for (int k = 1; k <= 24; k++) begin
            tick();
            tests_run++;
            if (busy0 !== (k < 16) || busy1 !== (k < 16) || busy2 !== (k < 20)) begin
                tests_failed++;
                $display("FAIL sweep_busy edge %0d: busy0=%b busy1=%b busy2=%b, required %b %b %b",
                         k, busy0, busy1, busy2, k < 16, k < 16, k < 20);
            end
            tests_run++;
            if (ra0 !== 32'h0 || rb0 !== 32'h0 || ra2 !== 16'h0) begin
                tests_failed++;
                $display("FAIL sweep_data edge %0d: ra0=%h rb0=%h ra2=%h, required 0", k, ra0, rb0, ra2);
            end
            if (k == 8) begin
                w0 = 1'b0; w1 = 1'b0; w2 = 1'b0;
            end
        end
    endtask

    task automatic test_clear_readback();
        for (int i = 0; i < 32; i++) begin
            a0 = 4'(i % 16); b0 = 4'(15 - i % 16);
            a1 = 4'(i % 16); b1 = 4'(15 - i % 16);
            a2 = 5'(i);      b2 = 5'(31 - i);
            tick_idle();
            tests_run++;
            if (ra0 !== 32'h0 || rb0 !== 32'h0 || ra1 !== 32'h0 || rb1 !== 32'h0 ||
                ra2 !== 16'h0 || rb2 !== 16'h0) begin
                tests_failed++;
                $display("FAIL clear_readback step %0d: %h %h %h %h %h %h, required all 0",
                         i, ra0, rb0, ra1, rb1, ra2, rb2);
            end
        end
    endtask

    task automatic test_basic();
        w0 = 1'b1; c0 = 4'd3; d0 = 32'h12345678;
        w1 = 1'b1; c1 = 4'd3; d1 = 32'h12345678;
        w2 = 1'b1; c2 = 5'd3; d2 = 16'h1234;
        tick_idle();
        a0 = 4'd3; b0 = 4'd3; a1 = 4'd3; b1 = 4'd3; a2 = 5'd3; b2 = 5'd3;
        tick_idle();
        tests_run++;
        if (ra0 !== 32'h12345678 || rb0 !== 32'h12345678 || ra1 !== 32'h12345678 ||
            rb1 !== 32'h12345678 || ra2 !== 16'h1234 || rb2 !== 16'h1234) begin
            tests_failed++;
            $display("FAIL basic_rw: %h %h %h %h %h %h, required 12345678 x4, 1234 x2",
                     ra0, rb0, ra1, rb1, ra2, rb2);
        end
    endtask

    task automatic test_zero_reg();
        w0 = 1'b1; c0 = 4'd0; d0 = 32'hFFFFFFFF;
        w1 = 1'b1; c1 = 4'd0; d1 = 32'hFFFFFFFF;
        w2 = 1'b1; c2 = 5'd0; d2 = 16'hFFFF;
        tick_idle();
        a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0; a2 = 5'd0; b2 = 5'd0;
        tick_idle();
        tests_run++;
        if (ra0 !== 32'h0 || rb0 !== 32'h0 || ra2 !== 16'h0) begin
            tests_failed++;
            $display("FAIL zero_reg_on: ra0=%h rb0=%h ra2=%h, required 0", ra0, rb0, ra2);
        end
        tests_run++;
        if (ra1 !== 32'hFFFFFFFF || rb1 !== 32'hFFFFFFFF) begin
            tests_failed++;
            $display("FAIL zero_reg_off: ra1=%h rb1=%h, required ffffffff", ra1, rb1);
        end
    endtask

    task automatic test_same_edge();
        logic [31:0] first;
`ifdef REGFILE_BYPASS_EN
        first = 32'h22;
`else
        first = 32'h11;
`endif
        w0 = 1'b1; c0 = 4'd7; d0 = 32'h11;
        w1 = 1'b1; c1 = 4'd7; d1 = 32'h11;
        tick_idle();
        w0 = 1'b1; c0 = 4'd7; d0 = 32'h22; a0 = 4'd7; b0 = 4'd7;
        w1 = 1'b1; c1 = 4'd7; d1 = 32'h22; a1 = 4'd7; b1 = 4'd7;
        tick_idle();
        tests_run++;
        if (ra0 !== first || rb0 !== first || ra1 !== first || rb1 !== first) begin
            tests_failed++;
            $display("FAIL same_edge_first: %h %h %h %h, required %h", ra0, rb0, ra1, rb1, first);
        end
        tick_idle();
        tests_run++;
        if (ra0 !== 32'h22 || rb0 !== 32'h22 || ra1 !== 32'h22) begin
            tests_failed++;
            $display("FAIL same_edge_next: %h %h %h, required 22", ra0, rb0, ra1);
        end
        // Dropped zero-register write must not be forwarded.
        w0 = 1'b1; c0 = 4'd0; d0 = 32'h33; a0 = 4'd0; b0 = 4'd0;
        tick_idle();
        tests_run++;
        if (ra0 !== 32'h0 || rb0 !== 32'h0) begin
            tests_failed++;
            $display("FAIL dropped_no_forward: ra0=%h rb0=%h, required 0", ra0, rb0);
        end
    endtask

    task automatic test_range();
        w2 = 1'b1; c2 = 5'd25; d2 = 16'h1111; a2 = 5'd25; b2 = 5'd20;
        tick_idle();
        tests_run++;
        if (ra2 !== 16'h0) begin
            tests_failed++;
            $display("FAIL range_same_edge: ra2=%h, required 0", ra2);
        end
        w2 = 1'b1; c2 = 5'd20; d2 = 16'h2222;
        tick_idle();
        tick_idle();
        tests_run++;
        if (ra2 !== 16'h0 || rb2 !== 16'h0) begin
            tests_failed++;
            $display("FAIL range_drop: ra2=%h rb2=%h, required 0", ra2, rb2);
        end
        w2 = 1'b1; c2 = 5'd19; d2 = 16'hA5A5;
        tick_idle();
        a2 = 5'd19; b2 = 5'd19;
        tick_idle();
        tests_run++;
        if (ra2 !== 16'hA5A5 || rb2 !== 16'hA5A5) begin
            tests_failed++;
            $display("FAIL range_top_entry: ra2=%h rb2=%h, required a5a5", ra2, rb2);
        end
    endtask

    task automatic test_random();
        logic [31:0] obs [6];
        logic [31:0] e;
        for (int n = 0; n < 300; n++) begin
            w0 = 1'($urandom_range(0, 1)); c0 = 4'($urandom_range(0, 15)); d0 = $urandom;
            a0 = 4'($urandom_range(0, 15)); b0 = 4'($urandom_range(0, 15));
            w1 = 1'($urandom_range(0, 1)); c1 = 4'($urandom_range(0, 15)); d1 = $urandom;
            a1 = 4'($urandom_range(0, 15)); b1 = 4'($urandom_range(0, 15));
            w2 = 1'($urandom_range(0, 1)); c2 = 5'($urandom_range(0, 31)); d2 = 16'($urandom);
            a2 = 5'($urandom_range(0, 31)); b2 = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) begin
                a0 = c0; b1 = c1; a2 = c2;
            end
            exp_q.push_back(exp0(int'(a0)));
            exp_q.push_back(exp0(int'(b0)));
            exp_q.push_back(exp1(int'(a1)));
            exp_q.push_back(exp1(int'(b1)));
            exp_q.push_back(exp2(int'(a2)));
            exp_q.push_back(exp2(int'(b2)));
            tick();
            obs[0] = ra0; obs[1] = rb0; obs[2] = ra1; obs[3] = rb1;
            obs[4] = {16'h0, ra2}; obs[5] = {16'h0, rb2};
            for (int j = 0; j < 6; j++) begin
                e = exp_q.pop_front();
                tests_run++;
                if (obs[j] !== e) begin
                    tests_failed++;
                    $display("FAIL random cycle %0d port %0d: got %h, required %h", n, j, obs[j], e);
                end
            end
            commit();
        end
        w0 = 1'b0; w1 = 1'b0; w2 = 1'b0;
    endtask

    task automatic test_mid_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        for (int k = 1; k <= 9; k++) tick();
        Reset = 1'b1;
        tick();
        tests_run++;
        if (busy0 !== 1'b1 || ra0 !== 32'h0) begin
            tests_failed++;
            $display("FAIL mid_reset_pulse: busy0=%b ra0=%h, required 1 and 0", busy0, ra0);
        end
        Reset = 1'b0;
        clear_model();
        for (int k = 1; k <= 22; k++) begin
            tick();
            tests_run++;
            if (busy0 !== (k < 16) || busy1 !== (k < 16) || busy2 !== (k < 20)) begin
                tests_failed++;
                $display("FAIL mid_reset_busy edge %0d: busy0=%b busy1=%b busy2=%b, required %b %b %b",
                         k, busy0, busy1, busy2, k < 16, k < 16, k < 20);
            end
        end
        for (int i = 0; i < 20; i++) begin
            a0 = 4'(i % 16); b1 = 4'(15 - i % 16); a2 = 5'(i);
            tick_idle();
            tests_run++;
            if (ra0 !== 32'h0 || rb1 !== 32'h0 || ra2 !== 16'h0) begin
                tests_failed++;
                $display("FAIL mid_reset_cleared step %0d: ra0=%h rb1=%h ra2=%h, required 0",
                         i, ra0, rb1, ra2);
            end
        end
    endtask

    // Test sequence and final report
    initial begin
        #1;
        test_reset();
        test_clear_readback();
        test_basic();
        test_zero_reg();
        test_same_edge();
        test_range();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
